// File: rtl/i2c_pkg.sv
// Shared constants and types for the 24C16-style I2C EEPROM master.
// Control byte layout is {device type, block address A10..A8, R/W}.
package i2c_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_SEND_BYTE = 3'd2;
    localparam logic [2:0] ST_GET_ACK   = 3'd3;
    localparam logic [2:0] ST_RSTART    = 3'd4;
    localparam logic [2:0] ST_RECV_BYTE = 3'd5;
    localparam logic [2:0] ST_SEND_NACK = 3'd6;
    localparam logic [2:0] ST_STOP      = 3'd7;

    typedef enum logic [1:0] {PH0 = 2'd0, PH1 = 2'd1, PH2 = 2'd2, PH3 = 2'd3} phase_e;

    typedef enum logic [1:0] {
        BSEL_CTRL   = 2'd0,
        BSEL_ADDR   = 2'd1,
        BSEL_DATA   = 2'd2,
        BSEL_CTRL_R = 2'd3
    } bsel_e;

    localparam logic [3:0] DEV_TYPE = 4'b1010;
    localparam logic       RW_WRITE = 1'b0;
    localparam logic       RW_READ  = 1'b1;

    function automatic logic [7:0] ctrl_byte(input logic [2:0] blk, input logic rw);
        return {DEV_TYPE, blk, rw};
    endfunction

    // Data-type bit slots hold SCL high during the second half of the slot.
    function automatic logic scl_high(input phase_e p);
        return (p == PH2) || (p == PH3);
    endfunction

endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-bit timebase: divides CLK by CLK_DIV and steps a 2-bit phase.
// Parked at phase 0 with a cleared divider whenever run is low.
module i2c_phase_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   run,
    output logic   tick,
    output phase_e phase
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    phase_e        phase_q, phase_d;

    assign tick  = run && (cnt_q == CW'(CLK_DIV - 1));
    assign phase = phase_q;

    // Next-state logic for the divider and phase counter.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!run) begin
            cnt_d   = '0;
            phase_d = PH0;
        end else if (tick) begin
            cnt_d   = '0;
            phase_d = phase_e'(phase_q + 2'd1);
        end else begin
            cnt_d   = cnt_q + CW'(1);
        end
    end

    // Divider and phase registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= PH0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/i2c_eeprom_master.sv
// Single-byte random write / random read master for a 24C16-style EEPROM.
// SCL is push-pull; SDA is open-drain (only ever pulled low).
module i2c_eeprom_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic [10:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic        scl,
    inout  wire         sda
);

    logic [2:0]  state_q, state_d;
    bsel_e       bsel_q, bsel_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [10:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        is_rd_q, is_rd_d;
    logic        samp_q, samp_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ack_err_q, ack_err_d;
    logic        scl_q, scl_d;
    logic        sda_oe_q, sda_oe_d;

    logic   tick, slot_end, samp_now, sda_in;
    phase_e phase, phase_n;

    i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
        .clk   (CLK),
        .rst   (RESET),
        .run   (state_q != ST_IDLE),
        .tick  (tick),
        .phase (phase)
    );

    assign sda_in   = sda;
    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign slot_end = tick && (phase == PH3);
    assign samp_now = tick && (phase == PH2);
    assign phase_n  = tick ? phase_e'(phase + 2'd1) : phase;

    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign scl     = scl_q;

    // Transaction sequencing; every state advances only at the end of its bit slot.
    always_comb begin
        state_d   = state_q;
        bsel_d    = bsel_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        is_rd_d   = is_rd_q;
        samp_d    = samp_now ? sda_in : samp_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_req || rd_req) begin
                    state_d   = ST_START;
                    addr_d    = addr;
                    wdata_d   = wdata;
                    is_rd_d   = !wr_req;
                    ack_err_d = 1'b0;
                    shift_d   = ctrl_byte(addr[10:8], RW_WRITE);
                    bsel_d    = BSEL_CTRL;
                    bit_d     = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (slot_end) state_d = ST_SEND_BYTE;
                else          state_d = ST_START;
            end
            ST_SEND_BYTE: begin
                if (slot_end && (bit_q == 3'd7)) begin
                    state_d = ST_GET_ACK;
                    bit_d   = 3'd0;
                end else if (slot_end) begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = {shift_q[6:0], 1'b0};
                end else begin
                    state_d = ST_SEND_BYTE;
                end
            end
            ST_GET_ACK: begin
                if (slot_end && samp_q) begin
                    ack_err_d = 1'b1;
                    state_d   = ST_STOP;
                end else if (slot_end) begin
                    case (bsel_q)
                        BSEL_CTRL: begin
                            shift_d = addr_q[7:0];
                            bsel_d  = BSEL_ADDR;
                            state_d = ST_SEND_BYTE;
                        end
                        BSEL_ADDR: begin
                            shift_d = wdata_q;
                            bsel_d  = BSEL_DATA;
                            state_d = is_rd_q ? ST_RSTART : ST_SEND_BYTE;
                        end
                        BSEL_CTRL_R: state_d = ST_RECV_BYTE;
                        default:     state_d = ST_STOP;
                    endcase
                end else begin
                    state_d = ST_GET_ACK;
                end
            end
            ST_RSTART: begin
                if (slot_end) begin
                    shift_d = ctrl_byte(addr_q[10:8], RW_READ);
                    bsel_d  = BSEL_CTRL_R;
                    state_d = ST_SEND_BYTE;
                end else begin
                    state_d = ST_RSTART;
                end
            end
            ST_RECV_BYTE: begin
                if (samp_now) begin
                    shift_d = {shift_q[6:0], sda_in};
                end else if (slot_end && (bit_q == 3'd7)) begin
                    state_d = ST_SEND_NACK;
                    bit_d   = 3'd0;
                end else if (slot_end) begin
                    bit_d = bit_q + 3'd1;
                end else begin
                    state_d = ST_RECV_BYTE;
                end
            end
            ST_SEND_NACK: begin
                if (slot_end) state_d = ST_STOP;
                else          state_d = ST_SEND_NACK;
            end
            ST_STOP: begin
                if (slot_end) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    rdata_d = (is_rd_q && !ack_err_q) ? shift_q : rdata_q;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus pin levels follow the upcoming state/phase; data lines only move at P1 while SCL is low.
    always_comb begin
        busy_d   = (state_d != ST_IDLE);
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        case (state_d)
            ST_IDLE: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
            ST_START: begin
                scl_d    = 1'b1;
                sda_oe_d = scl_high(phase_n);
            end
            ST_RSTART: begin
                scl_d    = (phase_n != PH0);
                sda_oe_d = (phase_n == PH3);
            end
            ST_STOP: begin
                scl_d    = (phase_n != PH0);
                sda_oe_d = (phase_n != PH3);
            end
            ST_SEND_BYTE: begin
                scl_d    = scl_high(phase_n);
                sda_oe_d = (phase_n == PH0) ? sda_oe_q : !shift_q[7];
            end
            default: begin
                scl_d    = scl_high(phase_n);
                sda_oe_d = (phase_n == PH0) ? sda_oe_q : 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            bsel_q    <= BSEL_CTRL;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            addr_q    <= 11'd0;
            wdata_q   <= 8'd0;
            is_rd_q   <= 1'b0;
            samp_q    <= 1'b1;
            rdata_q   <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bsel_q    <= bsel_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_rd_q   <= is_rd_d;
            samp_q    <= samp_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

endmodule
